// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with enable, sync clear/load, wrap-or-saturate and flags.
// Latency: Count and Wrap update 1 cycle after Clr/Load/En; Tc is combinational on Count and Up.
// Backpressure: none; En is the only throttle and the counter holds its value while En is low.
module counter_updown_mod #(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MOD      = 16,
    parameter bit              SAT_MODE = 1'b0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             En,
    input  logic             Up,
    input  logic             Clr,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_val,
    output logic [WIDTH-1:0] Count,
    output logic             Tc,
    output logic             Wrap
);

    // Refuse to elaborate with parameters the counter cannot honour.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("counter_updown_mod: WIDTH must be in 1..32");
        end
        if (MOD < 2 || MOD > (64'd1 << WIDTH)) begin : g_bad_mod
            $error("counter_updown_mod: MOD must satisfy 2 <= MOD <= 2**WIDTH");
        end
    endgenerate

    // One extra bit keeps MOD-1 and the increment representable when MOD == 2**WIDTH.
    localparam logic [WIDTH:0] ONE   = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] MAX_V = MOD[WIDTH:0] - ONE;

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   inc_v;
    logic [WIDTH:0]   dec_v;
    logic             at_top;
    logic             at_bottom;
    logic             unused_carry;

    assign count_ext    = {1'b0, count_q};
    assign inc_v        = count_ext + ONE;
    assign dec_v        = count_ext - ONE;
    assign at_top       = (count_ext == MAX_V);
    assign at_bottom    = (count_q == '0);
    // The carry/borrow bits are never needed: the end checks above catch both boundaries first.
    assign unused_carry = &{1'b0, inc_v[WIDTH], dec_v[WIDTH]};

    // Next-state: Clr beats Load beats En; Wrap only pulses on the edge that crosses an end.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (Clr) begin
            count_d = '0;
        end else if (Load) begin
            if ({1'b0, Load_val} > MAX_V) begin
                count_d = MAX_V[WIDTH-1:0];
            end else begin
                count_d = Load_val;
            end
        end else if (En) begin
            if (Up) begin
                if (at_top) begin
                    if (!SAT_MODE) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = inc_v[WIDTH-1:0];
                end
            end else begin
                if (at_bottom) begin
                    if (!SAT_MODE) begin
                        count_d = MAX_V[WIDTH-1:0];
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = dec_v[WIDTH-1:0];
                end
            end
        end
    end

    // State registers; reset clears count and any pending wrap pulse immediately.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Terminal count follows the current direction so cascades advance on the right end.
    always_comb begin
        Tc = Up ? at_top : at_bottom;
    end

    assign Count = count_q;
    assign Wrap  = wrap_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: wrap, saturate, modulus-16 and a two-digit cascade.
// Inputs change 1 time unit after a rising edge; outputs are checked before the next edge.
// All expected values are hand-derived constants or simple decimal arithmetic.
module tb_counter_updown_mod;

    logic clk;
    logic rst_n;

    // shared controls for the two MOD=10 instances
    logic       up, clr, load;
    logic [3:0] lv;
    logic       en0, en1;
    // controls for the modulus-16 instance
    logic       en2, up2;
    // cascade controls
    logic       en3;
    logic       zero_b;
    logic [3:0] zero_v;

    logic [3:0] cnt0, cnt1, cnt2, cnt_lo, cnt_hi;
    logic       tc0, tc1, tc2, tc_lo, tc_hi;
    logic       wr0, wr1, wr2, wr_lo, wr_hi;
    logic       en_hi;

    int total;
    int bad;

    counter_updown_mod #(.WIDTH(4), .MOD(10), .SAT_MODE(1'b0)) u_dut0 (
        .Clk(clk), .Rst_n(rst_n), .En(en0), .Up(up), .Clr(clr), .Load(load),
        .Load_val(lv), .Count(cnt0), .Tc(tc0), .Wrap(wr0)
    );

    counter_updown_mod #(.WIDTH(4), .MOD(10), .SAT_MODE(1'b1)) u_dut1 (
        .Clk(clk), .Rst_n(rst_n), .En(en1), .Up(up), .Clr(clr), .Load(load),
        .Load_val(lv), .Count(cnt1), .Tc(tc1), .Wrap(wr1)
    );

    counter_updown_mod #(.WIDTH(4), .MOD(16), .SAT_MODE(1'b0)) u_dut2 (
        .Clk(clk), .Rst_n(rst_n), .En(en2), .Up(up2), .Clr(zero_b), .Load(zero_b),
        .Load_val(zero_v), .Count(cnt2), .Tc(tc2), .Wrap(wr2)
    );

    assign en_hi = en3 & tc_lo;

    counter_updown_mod #(.WIDTH(4), .MOD(10), .SAT_MODE(1'b0)) u_lo (
        .Clk(clk), .Rst_n(rst_n), .En(en3), .Up(1'b1), .Clr(zero_b), .Load(zero_b),
        .Load_val(zero_v), .Count(cnt_lo), .Tc(tc_lo), .Wrap(wr_lo)
    );

    counter_updown_mod #(.WIDTH(4), .MOD(10), .SAT_MODE(1'b0)) u_hi (
        .Clk(clk), .Rst_n(rst_n), .En(en_hi), .Up(1'b1), .Clr(zero_b), .Load(zero_b),
        .Load_val(zero_v), .Count(cnt_hi), .Tc(tc_hi), .Wrap(wr_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        up     = 1'b1;
        clr    = 1'b0;
        load   = 1'b0;
        lv     = 4'd0;
        en0    = 1'b0;
        en1    = 1'b0;
        en2    = 1'b0;
        up2    = 1'b1;
        en3    = 1'b0;
        zero_b = 1'b0;
        zero_v = 4'd0;

        // reset state
        step();
        chk("rst_count", int'(cnt0), 0);
        chk("rst_wrap", int'(wr0), 0);
        chk("rst_tc_up", int'(tc0), 0);
        #3 rst_n = 1'b1;

        // count to 7, then assert reset between edges
        en0 = 1'b1;
        up  = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk("pre_rst_count", int'(cnt0), i);
        end
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_count", int'(cnt0), 0);
        chk("async_rst_wrap", int'(wr0), 0);
        step();
        chk("held_rst_count", int'(cnt0), 0);
        #3 rst_n = 1'b1;
        step();
        chk("post_rst_count", int'(cnt0), 1);

        // clear beats enable
        clr = 1'b1;
        step();
        chk("clr_over_en", int'(cnt0), 0);
        clr = 1'b0;

        // 12 up edges from 0: 1..9, 0, 1, 2
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("up_count", int'(cnt0), i % 10);
            chk("up_wrap", int'(wr0), (i == 10) ? 1 : 0);
            chk("up_tc", int'(tc0), (i == 9) ? 1 : 0);
        end

        // down from 0: wrap instance vs saturating instance
        clr = 1'b1;
        step();
        chk("clr_count", int'(cnt0), 0);
        clr = 1'b0;
        up  = 1'b0;
        en1 = 1'b1;
        #1;
        chk("dn_tc0_at0", int'(tc0), 1);
        chk("sat_tc_at0", int'(tc1), 1);
        step();
        chk("dn_count_9", int'(cnt0), 9);
        chk("dn_wrap_pulse", int'(wr0), 1);
        chk("sat_dn_hold", int'(cnt1), 0);
        chk("sat_dn_wrap", int'(wr1), 0);
        chk("sat_dn_tc", int'(tc1), 1);
        step();
        chk("dn_count_8", int'(cnt0), 8);
        chk("dn_wrap_drop", int'(wr0), 0);
        chk("sat_dn_hold2", int'(cnt1), 0);
        chk("sat_dn_wrap2", int'(wr1), 0);
        en1 = 1'b0;

        // out-of-range load clamps to 9 in both instances
        en0  = 1'b0;
        load = 1'b1;
        lv   = 4'd13;
        step();
        chk("load_clamp", int'(cnt0), 9);
        chk("load_clamp_sat", int'(cnt1), 9);
        chk("load_wrap", int'(wr0), 0);
        load = 1'b0;

        // saturating instance holds at the top going up
        up  = 1'b1;
        en1 = 1'b1;
        #1;
        chk("sat_tc_top", int'(tc1), 1);
        step();
        chk("sat_up_hold", int'(cnt1), 9);
        chk("sat_up_wrap", int'(wr1), 0);
        chk("en_off_hold", int'(cnt0), 9);
        en1 = 1'b0;

        // clear beats load beats enable
        clr  = 1'b1;
        load = 1'b1;
        en0  = 1'b1;
        lv   = 4'd5;
        step();
        chk("clr_load_en", int'(cnt0), 0);
        clr = 1'b0;
        lv  = 4'd4;
        step();
        chk("load_over_en", int'(cnt0), 4);
        load = 1'b0;
        en0  = 1'b0;

        // enable toggling from 3
        load = 1'b1;
        lv   = 4'd3;
        step();
        chk("load3", int'(cnt0), 3);
        load = 1'b0;
        en0 = 1'b1; step(); chk("en_tog1", int'(cnt0), 4);
        en0 = 1'b0; step(); chk("en_tog0", int'(cnt0), 4);
        en0 = 1'b1; step(); chk("en_tog1b", int'(cnt0), 5);
        en0 = 1'b0; step(); chk("en_tog0b", int'(cnt0), 5);

        // direction flip right after an increment edge
        en0 = 1'b1;
        step();
        chk("flip_inc", int'(cnt0), 6);
        up = 1'b0;
        step();
        chk("flip_dec", int'(cnt0), 5);
        en0 = 1'b0;

        // modulus 16: 0 -> 15 -> 0
        en2 = 1'b1;
        up2 = 1'b0;
        step();
        chk("m16_down", int'(cnt2), 15);
        chk("m16_down_wrap", int'(wr2), 1);
        up2 = 1'b1;
        #1;
        chk("m16_tc15", int'(tc2), 1);
        step();
        chk("m16_up", int'(cnt2), 0);
        chk("m16_up_wrap", int'(wr2), 1);
        en2 = 1'b0;
        step();
        chk("m16_wrap_drop", int'(wr2), 0);

        // two-digit decimal cascade 00..99 -> 00
        en3 = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            chk("cas_lo", int'(cnt_lo), i % 10);
            chk("cas_hi", int'(cnt_hi), (i / 10) % 10);
        end
        chk("cas_hi_wrap", int'(wr_hi), 1);
        en3 = 1'b0;
        step();
        chk("cas_hi_wrap_drop", int'(wr_hi), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
